// File: rtl/rx_intf_m_axis_arbiter_if.sv
// rx_intf_m_axis_arbiter_if: stream sources and m_axis side of the arbiter.
// slave = arbiter; master = requesters plus the m_axis DMA channel.
interface rx_intf_m_axis_arbiter_if #(
  parameter int DW = 64,
  parameter int NW = 14
);
  logic          req0_start;
  logic          req1_start;
  logic [NW-1:0] req0_num_symbol;
  logic [NW-1:0] req1_num_symbol;
  logic [DW-1:0] req0_data;
  logic [DW-1:0] req1_data;
  logic          req0_data_valid;
  logic          req1_data_valid;
  logic          m_axis_tlast;
  logic          start_1trans_to_m_axis;
  logic [DW-1:0] data_to_m_axis_out;
  logic          data_ready_to_m_axis_out;
  logic [NW-1:0] monitor_num_dma_symbol_to_ps;
  logic          m_axis_rst;

  modport slave (
    input  req0_start, req1_start,
    input  req0_num_symbol, req1_num_symbol,
    input  req0_data, req1_data,
    input  req0_data_valid, req1_data_valid,
    input  m_axis_tlast,
    output start_1trans_to_m_axis,
    output data_to_m_axis_out,
    output data_ready_to_m_axis_out,
    output monitor_num_dma_symbol_to_ps,
    output m_axis_rst
  );

  modport master (
    output req0_start, req1_start,
    output req0_num_symbol, req1_num_symbol,
    output req0_data, req1_data,
    output req0_data_valid, req1_data_valid,
    output m_axis_tlast,
    input  start_1trans_to_m_axis,
    input  data_to_m_axis_out,
    input  data_ready_to_m_axis_out,
    input  monitor_num_dma_symbol_to_ps,
    input  m_axis_rst
  );
endinterface

// File: rtl/rx_intf_m_axis_arbiter.sv
// rx_intf_m_axis_arbiter: shares the rx m_axis DMA channel between the
// wifi packet stream (req0) and the IQ capture stream (req1).
// Ports: clk, rst (async high); bus (slave modport: requests, data,
// tlast in; start pulse, data, ready, word count, m_axis_rst out);
// i_arb_mode, i_timeout_enable, i_timeout_top, i_tsf_pulse_1M in;
// o_grant, o_timeout_event, o_drop_count0/1 out.
module rx_intf_m_axis_arbiter #(
  parameter int C_M00_AXIS_TDATA_WIDTH = 64,
  parameter int MAX_BIT_NUM_DMA_SYMBOL = 14,
  parameter int TIMEOUT_WIDTH          = 13
) (
  input  logic                     clk,
  input  logic                     rst,
  rx_intf_m_axis_arbiter_if.slave  bus,
  input  logic [1:0]               i_arb_mode,
  input  logic                     i_timeout_enable,
  input  logic [TIMEOUT_WIDTH-1:0] i_timeout_top,
  input  logic                     i_tsf_pulse_1M,
  output logic [1:0]               o_grant,
  output logic                     o_timeout_event,
  output logic [7:0]               o_drop_count0,
  output logic [7:0]               o_drop_count1
);
  localparam int DW = C_M00_AXIS_TDATA_WIDTH;
  localparam int NW = MAX_BIT_NUM_DMA_SYMBOL;
  localparam int TW = TIMEOUT_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE, S_START, S_STREAM, S_RECOVER
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_pend0, r_pend1;
  logic [NW-1:0] r_num0, r_num1;
  logic [NW-1:0] r_mon, w_mon_nxt;
  logic          r_last, w_last_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt, w_timer_inc;
  logic [2:0]    r_rcnt, w_rcnt_nxt;
  logic [1:0]    r_grant, w_grant_nxt;
  logic          r_start, r_mrst, r_tev, w_tev_nxt;
  logic [DW-1:0] r_data, w_src_data;
  logic          r_rdy, w_src_vld;
  logic [7:0]    r_drop0, r_drop1;
  logic          w_arb, w_win, w_clr0, w_clr1;
  logic          w_set0, w_set1, w_drop0, w_drop1;

  // w_win: 0 selects req0, 1 selects req1
  always_comb begin
    w_win = 1'b0;
    unique case (1'b1)
      (i_arb_mode == 2'd0): w_win = !r_pend0;
      (i_arb_mode == 2'd1): w_win = r_pend1;
      default: w_win = (r_pend0 && r_pend1) ? !r_last : r_pend1;
    endcase
  end

  assign w_arb  = (r_state == S_IDLE) && (i_arb_mode != 2'd3)
               && (r_pend0 || r_pend1);
  assign w_clr0 = w_arb && !w_win;
  assign w_clr1 = w_arb && w_win;

  // a slot freed by this cycle's grant may be refilled at once
  assign w_set0  = bus.req0_start && (bus.req0_num_symbol != '0)
                && (!r_pend0 || w_clr0);
  assign w_set1  = bus.req1_start && (bus.req1_num_symbol != '0)
                && (!r_pend1 || w_clr1);
  assign w_drop0 = bus.req0_start && !w_set0;
  assign w_drop1 = bus.req1_start && !w_set1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend0 <= 1'b0;
      r_pend1 <= 1'b0;
      r_num0  <= '0;
      r_num1  <= '0;
      r_drop0 <= '0;
      r_drop1 <= '0;
    end else begin
      if (w_set0) begin
        r_pend0 <= 1'b1;
        r_num0  <= bus.req0_num_symbol;
      end else if (w_clr0) begin
        r_pend0 <= 1'b0;
      end
      if (w_set1) begin
        r_pend1 <= 1'b1;
        r_num1  <= bus.req1_num_symbol;
      end else if (w_clr1) begin
        r_pend1 <= 1'b0;
      end
      if (w_drop0 && (r_drop0 != 8'hFF)) r_drop0 <= r_drop0 + 8'd1;
      if (w_drop1 && (r_drop1 != 8'hFF)) r_drop1 <= r_drop1 + 8'd1;
    end
  end

  assign w_timer_inc = (&r_timer) ? r_timer
                     : r_timer + TW'(i_tsf_pulse_1M);
  assign w_src_data  = r_grant[1] ? bus.req1_data : bus.req0_data;
  assign w_src_vld   = r_grant[1] ? bus.req1_data_valid
                                  : bus.req0_data_valid;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_mon_nxt   = r_mon;
    w_last_nxt  = r_last;
    w_timer_nxt = r_timer;
    w_rcnt_nxt  = r_rcnt;
    w_tev_nxt   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_grant_nxt = 2'b00;
        if (w_arb) begin
          w_grant_nxt = w_win ? 2'b10 : 2'b01;
          w_mon_nxt   = w_win ? r_num1 : r_num0;
          w_last_nxt  = w_win;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_timer_nxt = '0;
        w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        if (bus.m_axis_tlast) begin
          w_grant_nxt = 2'b00;
          w_state_nxt = S_IDLE;
        end else begin
          w_timer_nxt = w_timer_inc;
          if (i_timeout_enable && (r_timer > i_timeout_top)) begin
            w_tev_nxt   = 1'b1;
            w_grant_nxt = 2'b00;
            w_mon_nxt   = '0;
            w_rcnt_nxt  = '0;
            w_state_nxt = S_RECOVER;
          end
        end
      end
      default: begin
        if (r_rcnt == 3'd7) w_state_nxt = S_IDLE;
        else                w_rcnt_nxt  = r_rcnt + 3'd1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_grant <= 2'b00;
      r_mon   <= '0;
      r_last  <= 1'b1;
      r_timer <= '0;
      r_rcnt  <= '0;
      r_tev   <= 1'b0;
      r_start <= 1'b0;
      r_mrst  <= 1'b0;
      r_data  <= '0;
      r_rdy   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_mon   <= w_mon_nxt;
      r_last  <= w_last_nxt;
      r_timer <= w_timer_nxt;
      r_rcnt  <= w_rcnt_nxt;
      r_tev   <= w_tev_nxt;
      r_start <= (w_state_nxt == S_START);
      r_mrst  <= (w_state_nxt == S_RECOVER);
      r_data  <= (r_state == S_STREAM) ? w_src_data : '0;
      r_rdy   <= (r_state == S_STREAM) && w_src_vld;
    end
  end

  assign bus.start_1trans_to_m_axis       = r_start;
  assign bus.data_to_m_axis_out           = r_data;
  assign bus.data_ready_to_m_axis_out     = r_rdy;
  assign bus.monitor_num_dma_symbol_to_ps = r_mon;
  assign bus.m_axis_rst                   = r_mrst;
  assign o_grant         = r_grant;
  assign o_timeout_event = r_tev;
  assign o_drop_count0   = r_drop0;
  assign o_drop_count1   = r_drop1;
endmodule

// File: tb/tb_rx_intf_m_axis_arbiter.sv
// tb_rx_intf_m_axis_arbiter: randomized scenario bench for the
// rx m_axis arbiter against a request/grant reference model.
module tb_rx_intf_m_axis_arbiter;
  localparam int DW = 64;
  localparam int NW = 14;
  localparam int TW = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    arb_mode;
  logic          ten;
  logic [TW-1:0] ttop;
  logic          tsf;
  logic [1:0]    grant;
  logic          tev;
  logic [7:0]    drop0, drop1;
  int            checks = 0;
  int            failures = 0;

  rx_intf_m_axis_arbiter_if #(.DW(DW), .NW(NW)) bus ();

  rx_intf_m_axis_arbiter #(
    .C_M00_AXIS_TDATA_WIDTH(DW),
    .MAX_BIT_NUM_DMA_SYMBOL(NW),
    .TIMEOUT_WIDTH(TW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .i_arb_mode      (arb_mode),
    .i_timeout_enable(ten),
    .i_timeout_top   (ttop),
    .i_tsf_pulse_1M  (tsf),
    .o_grant         (grant),
    .o_timeout_event (tev),
    .o_drop_count0   (drop0),
    .o_drop_count1   (drop1)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NW-1:0] rnum();
    return NW'($urandom_range(1, (1 << NW) - 1));
  endfunction

  task automatic idle_inputs;
    bus.req0_start      = 1'b0;
    bus.req1_start      = 1'b0;
    bus.req0_num_symbol = '0;
    bus.req1_num_symbol = '0;
    bus.req0_data       = '0;
    bus.req1_data       = '0;
    bus.req0_data_valid = 1'b0;
    bus.req1_data_valid = 1'b0;
    bus.m_axis_tlast    = 1'b0;
    tsf                 = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    arb_mode = 2'd0;
    ten      = 1'b0;
    ttop     = '0;
    rst      = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic pulse_req(input bit s, input logic [NW-1:0] n);
    if (s) begin
      bus.req1_start = 1'b1;
      bus.req1_num_symbol = n;
    end else begin
      bus.req0_start = 1'b1;
      bus.req0_num_symbol = n;
    end
    tick();
    bus.req0_start = 1'b0;
    bus.req1_start = 1'b0;
  endtask

  task automatic send_tlast;
    bus.m_axis_tlast = 1'b1;
    tick();
    bus.m_axis_tlast = 1'b0;
  endtask

  task automatic wait_start(input string name);
    int n = 0;
    while (bus.start_1trans_to_m_axis !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (bus.start_1trans_to_m_axis !== 1'b1) begin
      failures++;
      $display("FAIL %s: start pulse got %b want 1 within 20 cycles",
               name, bus.start_1trans_to_m_axis);
    end
  endtask

  task automatic test_reset;
    idle_inputs();
    arb_mode = 2'd0;
    ten = 1'b0;
    ttop = '0;
    rst = 1'b1;
    tick();
    checks++;
    if ({grant, bus.start_1trans_to_m_axis, bus.data_ready_to_m_axis_out,
         bus.m_axis_rst, tev} !== 6'd0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {grant, bus.start_1trans_to_m_axis,
                bus.data_ready_to_m_axis_out, bus.m_axis_rst, tev});
    end
    checks++;
    if (bus.data_to_m_axis_out !== '0) begin
      failures++;
      $display("FAIL reset_data: got %h want 0", bus.data_to_m_axis_out);
    end
    checks++;
    if (bus.monitor_num_dma_symbol_to_ps !== '0) begin
      failures++;
      $display("FAIL reset_mon: got %0d want 0",
               bus.monitor_num_dma_symbol_to_ps);
    end
    checks++;
    if ({drop0, drop1} !== 16'd0) begin
      failures++;
      $display("FAIL reset_drops: got %0d/%0d want 0/0", drop0, drop1);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fixed_priority;
    bit f;
    logic [NW-1:0] n0, n1;
    do_reset();
    f = 1'($urandom_range(0, 1));
    arb_mode = {1'b0, f};
    n0 = rnum();
    n1 = rnum();
    bus.req0_num_symbol = n0;
    bus.req1_num_symbol = n1;
    bus.req0_start = 1'b1;
    bus.req1_start = 1'b1;
    tick();
    bus.req0_start = 1'b0;
    bus.req1_start = 1'b0;
    wait_start("fixed_first");
    checks++;
    if (grant !== (f ? 2'b10 : 2'b01)) begin
      failures++;
      $display("FAIL fixed_grant1 mode%0d: got %b want %b",
               f, grant, f ? 2'b10 : 2'b01);
    end
    checks++;
    if (bus.monitor_num_dma_symbol_to_ps !== (f ? n1 : n0)) begin
      failures++;
      $display("FAIL fixed_mon1: got %0d want %0d",
               bus.monitor_num_dma_symbol_to_ps, f ? n1 : n0);
    end
    tick();
    tick();
    send_tlast();
    checks++;
    if ({grant, bus.start_1trans_to_m_axis} !== 3'b000) begin
      failures++;
      $display("FAIL idle_after_tlast: got %b want 000",
               {grant, bus.start_1trans_to_m_axis});
    end
    tick();
    checks++;
    if (bus.start_1trans_to_m_axis !== 1'b1) begin
      failures++;
      $display("FAIL b2b_latency: start got %b want 1 two cycles after tlast",
               bus.start_1trans_to_m_axis);
    end
    checks++;
    if (grant !== (f ? 2'b01 : 2'b10)) begin
      failures++;
      $display("FAIL fixed_grant2: got %b want %b",
               grant, f ? 2'b01 : 2'b10);
    end
    checks++;
    if (bus.monitor_num_dma_symbol_to_ps !== (f ? n0 : n1)) begin
      failures++;
      $display("FAIL fixed_mon2: got %0d want %0d",
               bus.monitor_num_dma_symbol_to_ps, f ? n0 : n1);
    end
    tick();
    send_tlast();
  endtask

  task automatic test_round_robin;
    bit p0, p1, last, w, r0, r1;
    logic [NW-1:0] q0, q1;
    do_reset();
    arb_mode = 2'd2;
    last = 1'b1;
    q0 = rnum();
    q1 = rnum();
    bus.req0_num_symbol = q0;
    bus.req1_num_symbol = q1;
    bus.req0_start = 1'b1;
    bus.req1_start = 1'b1;
    tick();
    bus.req0_start = 1'b0;
    bus.req1_start = 1'b0;
    p0 = 1'b1;
    p1 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_start("rr_start");
      w = (p0 && p1) ? !last : p1;
      checks++;
      if (grant !== (w ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL rr_grant[%0d]: got %b want %b",
                 k, grant, w ? 2'b10 : 2'b01);
      end
      checks++;
      if (bus.monitor_num_dma_symbol_to_ps !== (w ? q1 : q0)) begin
        failures++;
        $display("FAIL rr_mon[%0d]: got %0d want %0d", k,
                 bus.monitor_num_dma_symbol_to_ps, w ? q1 : q0);
      end
      if (w) p1 = 1'b0;
      else   p0 = 1'b0;
      last = w;
      tick();
      r0 = 1'b0;
      r1 = 1'b0;
      if (k < 7) begin
        r0 = !p0 && ($urandom_range(0, 3) != 0);
        r1 = !p1 && ($urandom_range(0, 3) != 0);
        if (!(p0 || p1 || r0 || r1)) r0 = 1'b1;
      end
      if (r0) begin
        q0 = rnum();
        bus.req0_num_symbol = q0;
        bus.req0_start = 1'b1;
        p0 = 1'b1;
      end
      if (r1) begin
        q1 = rnum();
        bus.req1_num_symbol = q1;
        bus.req1_start = 1'b1;
        p1 = 1'b1;
      end
      tick();
      bus.req0_start = 1'b0;
      bus.req1_start = 1'b0;
      send_tlast();
    end
    checks++;
    if ({drop0, drop1} !== 16'd0) begin
      failures++;
      $display("FAIL rr_drops: got %0d/%0d want 0/0", drop0, drop1);
    end
  endtask

  task automatic test_drop;
    int extra, expd;
    bit seen;
    logic [NW-1:0] a, b;
    do_reset();
    arb_mode = 2'd3;
    a = rnum();
    pulse_req(1'b0, a);
    extra = $urandom_range(1, 300);
    expd = (extra > 255) ? 255 : extra;
    seen = 1'b0;
    for (int i = 0; i < extra; i++) begin
      pulse_req(1'b0, NW'($urandom));
      if (bus.start_1trans_to_m_axis === 1'b1 || grant !== 2'b00)
        seen = 1'b1;
    end
    pulse_req(1'b1, '0);
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL mode3_no_grant: activity got %b want 0", seen);
    end
    checks++;
    if (drop0 !== 8'(expd)) begin
      failures++;
      $display("FAIL drop0_count: got %0d want %0d", drop0, expd);
    end
    checks++;
    if (drop1 !== 8'd1) begin
      failures++;
      $display("FAIL drop1_zero_num: got %0d want 1", drop1);
    end
    arb_mode = 2'd0;
    b = rnum();
    pulse_req(1'b0, b);
    wait_start("drop_start1");
    checks++;
    if ({grant, bus.monitor_num_dma_symbol_to_ps} !== {2'b01, a}) begin
      failures++;
      $display("FAIL drop_kept_first: got %b/%0d want 01/%0d",
               grant, bus.monitor_num_dma_symbol_to_ps, a);
    end
    tick();
    send_tlast();
    wait_start("drop_start2");
    checks++;
    if ({grant, bus.monitor_num_dma_symbol_to_ps} !== {2'b01, b}) begin
      failures++;
      $display("FAIL set_wins_clear: got %b/%0d want 01/%0d",
               grant, bus.monitor_num_dma_symbol_to_ps, b);
    end
    checks++;
    if (drop0 !== 8'(expd)) begin
      failures++;
      $display("FAIL set_wins_nodrop: got %0d want %0d", drop0, expd);
    end
    tick();
    send_tlast();
  endtask

  task automatic test_timeout;
    int cnt, n;
    bit t, expv, fired;
    do_reset();
    ten = 1'b1;
    ttop = TW'($urandom_range(1, 6));
    pulse_req(1'b0, rnum());
    wait_start("to_start");
    tsf = 1'($urandom_range(0, 1));
    tick();
    cnt = 0;
    fired = 1'b0;
    for (int c = 0; c < 200 && !fired; c++) begin
      expv = (cnt > int'(ttop));
      t = 1'($urandom_range(0, 1));
      tsf = t;
      tick();
      checks++;
      if (tev !== expv) begin
        failures++;
        $display("FAIL timeout_event c%0d ticks=%0d top=%0d: got %b want %b",
                 c, cnt, ttop, tev, expv);
      end
      if (expv) fired = 1'b1;
      else      cnt += int'(t);
    end
    tsf = 1'b0;
    checks++;
    if ({bus.m_axis_rst, grant, bus.monitor_num_dma_symbol_to_ps}
        !== {1'b1, 2'b00, NW'(0)}) begin
      failures++;
      $display("FAIL recover_entry: mrst=%b grant=%b mon=%0d want 1/00/0",
               bus.m_axis_rst, grant, bus.monitor_num_dma_symbol_to_ps);
    end
    tick();
    checks++;
    if (tev !== 1'b0) begin
      failures++;
      $display("FAIL timeout_pulse_width: got %b want 0", tev);
    end
    n = 1;
    while (bus.m_axis_rst === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    checks++;
    if (n != 8) begin
      failures++;
      $display("FAIL m_axis_rst_len: got %0d want 8 cycles", n);
    end
    pulse_req(1'b0, rnum());
    wait_start("to_recovered");
    checks++;
    if (grant !== 2'b01) begin
      failures++;
      $display("FAIL recovered_grant: got %b want 01", grant);
    end
    tick();
    send_tlast();
  endtask

  task automatic test_data_forward;
    logic [DW-1:0] d0, d1;
    bit v0, v1;
    for (int s = 0; s < 2; s++) begin
      do_reset();
      pulse_req(1'(s), rnum());
      wait_start("fwd_start");
      tick();
      checks++;
      if (bus.data_ready_to_m_axis_out !== 1'b0) begin
        failures++;
        $display("FAIL fwd_first_ready: got %b want 0",
                 bus.data_ready_to_m_axis_out);
      end
      for (int i = 0; i < 24; i++) begin
        d0 = {$urandom, $urandom};
        d1 = {$urandom, $urandom};
        v0 = 1'($urandom_range(0, 1));
        v1 = 1'($urandom_range(0, 1));
        bus.req0_data = d0;
        bus.req1_data = d1;
        bus.req0_data_valid = v0;
        bus.req1_data_valid = v1;
        tick();
        checks++;
        if (bus.data_ready_to_m_axis_out !== (s ? v1 : v0)) begin
          failures++;
          $display("FAIL fwd_ready src%0d[%0d]: got %b want %b", s, i,
                   bus.data_ready_to_m_axis_out, s ? v1 : v0);
        end
        checks++;
        if (bus.data_to_m_axis_out !== (s ? d1 : d0)) begin
          failures++;
          $display("FAIL fwd_data src%0d[%0d]: got %h want %h", s, i,
                   bus.data_to_m_axis_out, s ? d1 : d0);
        end
      end
      bus.req0_data_valid = 1'b0;
      bus.req1_data_valid = 1'b0;
      send_tlast();
    end
  endtask

  task automatic test_reset_midstream;
    bit seen;
    do_reset();
    bus.req0_num_symbol = rnum();
    bus.req1_num_symbol = rnum();
    bus.req0_start = 1'b1;
    bus.req1_start = 1'b1;
    tick();
    bus.req0_start = 1'b0;
    bus.req1_start = 1'b0;
    wait_start("mid_start");
    tick();
    bus.req0_data = {$urandom, $urandom};
    bus.req0_data_valid = 1'b1;
    tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({grant, bus.data_ready_to_m_axis_out,
         bus.start_1trans_to_m_axis, bus.m_axis_rst, tev} !== 6'd0 ||
        bus.data_to_m_axis_out !== '0 ||
        bus.monitor_num_dma_symbol_to_ps !== '0) begin
      failures++;
      $display("FAIL async_reset: grant=%b rdy=%b data=%h mon=%0d want 0",
               grant, bus.data_ready_to_m_axis_out,
               bus.data_to_m_axis_out, bus.monitor_num_dma_symbol_to_ps);
    end
    rst = 1'b0;
    idle_inputs();
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.start_1trans_to_m_axis === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL pending_cleared: start seen %b want 0", seen);
    end
    arb_mode = 2'd3;
    bus.req0_num_symbol = rnum();
    bus.req1_num_symbol = rnum();
    bus.req0_start = 1'b1;
    bus.req1_start = 1'b1;
    tick();
    bus.req0_start = 1'b0;
    bus.req1_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.start_1trans_to_m_axis === 1'b1 || grant !== 2'b00)
        seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL mode3_idle: activity got %b want 0", seen);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_drop();
    test_timeout();
    test_data_forward();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
